display_scan: RTL

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_scan.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/display_scan.sv
// display_scan: captures two 3-bit operands and a 6-bit result. It converts the
// result to BCD one bit per cycle using shift-add-3. It then time-multiplexes
// four 7-segment digits: A, B, tens and units.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks the tens segments when the
// tens digit is 0. The digit enable for tens stays asserted while it is blanked.
module display_scan #(
  parameter int REFRESH_DIV = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       clear,
  input  logic [2:0] a_in,
  input  logic [2:0] b_in,
  input  logic [5:0] result_in,
  output logic [6:0] seg,
  output logic [3:0] digit_en,
  output logic       busy,
  output logic       ready
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, DISPLAY} state_t;

  state_t           state, state_nx;
  logic [2:0]       a_cap, a_nx;
  logic [2:0]       b_cap, b_nx;
  logic [5:0]       sh, sh_nx;
  logic [3:0]       wt, wt_nx;
  logic [3:0]       wu, wu_nx;
  logic [2:0]       step, step_nx;
  logic [3:0]       tens, tens_nx;
  logic [3:0]       units, units_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       idx, idx_nx;
  logic [3:0]       t_adj, u_adj, dig_nx;
  logic [6:0]       seg_nx;
  logic [3:0]       en_nx;
  logic             busy_nx, ready_nx;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h3F;
      4'd1:    seg_code = 7'h06;
      4'd2:    seg_code = 7'h5B;
      4'd3:    seg_code = 7'h4F;
      4'd4:    seg_code = 7'h66;
      4'd5:    seg_code = 7'h6D;
      4'd6:    seg_code = 7'h7D;
      4'd7:    seg_code = 7'h07;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h6F;
      default: seg_code = 7'h00;
    endcase
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] d);
    add3 = (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Next-state, conversion step, scan advance and registered-output values
  always_comb begin
    state_nx = state;
    a_nx     = a_cap;
    b_nx     = b_cap;
    sh_nx    = sh;
    wt_nx    = wt;
    wu_nx    = wu;
    step_nx  = step;
    tens_nx  = tens;
    units_nx = units;
    cnt_nx   = cnt;
    idx_nx   = idx;
    t_adj    = add3(wt);
    u_adj    = add3(wu);

    if (clear) begin
      state_nx = IDLE;
      tens_nx  = 4'd0;
      units_nx = 4'd0;
      cnt_nx   = '0;
      idx_nx   = 2'd3;
    end else begin
      case (state)
        IDLE, DISPLAY: begin
          if (load) begin
            a_nx     = a_in;
            b_nx     = b_in;
            sh_nx    = result_in;
            wt_nx    = 4'd0;
            wu_nx    = 4'd0;
            step_nx  = 3'd0;
            state_nx = CONVERT;
          end
        end
        CONVERT: begin
          if (step == 3'd6) begin
            tens_nx  = wt;
            units_nx = wu;
            state_nx = DISPLAY;
          end else begin
            wt_nx   = {t_adj[2:0], u_adj[3]};
            wu_nx   = {u_adj[2:0], sh[5]};
            sh_nx   = {sh[4:0], 1'b0};
            step_nx = step + 3'd1;
          end
        end
        default: state_nx = IDLE;
      endcase

      // IDLE parks the scan at digit A. A fresh load from IDLE therefore
      // starts there, and a reload from DISPLAY keeps scanning in phase.
      if (state == IDLE) begin
        cnt_nx = '0;
        idx_nx = 2'd3;
      end else if (cnt == CNT_MAX) begin
        cnt_nx = '0;
        idx_nx = idx - 2'd1;
      end else begin
        cnt_nx = cnt + CNT_W'(1);
      end
    end

    case (idx_nx)
      2'd3:    dig_nx = {1'b0, a_nx};
      2'd2:    dig_nx = {1'b0, b_nx};
      2'd1:    dig_nx = tens_nx;
      default: dig_nx = units_nx;
    endcase

    seg_nx = 7'h00;
    en_nx  = 4'b0000;
    if (state_nx != IDLE) begin
      seg_nx = seg_code(dig_nx);
      en_nx  = 4'b0001 << idx_nx;
`ifdef LEADING_ZERO_BLANK_EN
      if (idx_nx == 2'd1 && tens_nx == 4'd0) seg_nx = 7'h00;
`endif
    end
    busy_nx  = (state == CONVERT) && (state_nx == CONVERT);
    ready_nx = (state_nx == DISPLAY);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Captured operands, BCD work registers, scan counters and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_cap    <= '0;
      b_cap    <= '0;
      sh       <= '0;
      wt       <= '0;
      wu       <= '0;
      step     <= '0;
      tens     <= '0;
      units    <= '0;
      cnt      <= '0;
      idx      <= 2'd3;
      seg      <= '0;
      digit_en <= '0;
      busy     <= 1'b0;
      ready    <= 1'b0;
    end else begin
      a_cap    <= a_nx;
      b_cap    <= b_nx;
      sh       <= sh_nx;
      wt       <= wt_nx;
      wu       <= wu_nx;
      step     <= step_nx;
      tens     <= tens_nx;
      units    <= units_nx;
      cnt      <= cnt_nx;
      idx      <= idx_nx;
      seg      <= seg_nx;
      digit_en <= en_nx;
      busy     <= busy_nx;
      ready    <= ready_nx;
    end
  end

endmodule
